// File: rtl/argmax_classifier.sv
// argmax_classifier: final LeNet-5 stage. Captures the 10 class scores from fc_2,
// scans them one per cycle for the largest signed value (lowest index wins ties),
// writes the winning index to result BRAM and then strobes class_valid.
// Optional build macro: ARGMAX_TOP2_EN adds runner-up tracking, the second_idx and
// class_margin ports and a second BRAM write of the runner-up index.
module argmax_classifier #(
  parameter int DATA_SIZE   = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4,
  parameter int RESULT_ADDR = 8094
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           argmax_en,
  input  logic                           scores_valid,
  input  logic [DATA_SIZE*NUM_CLASSES-1:0] scores_in,
  output logic                           result_bram_ena,
  output logic                           result_bram_wea,
  output logic [12:0]                    result_bram_addra,
  output logic [DATA_SIZE-1:0]           result_bram_dina,
  output logic [IDX_W-1:0]               class_idx,
  output logic [DATA_SIZE-1:0]           class_score,
  output logic                           class_valid,
  output logic                           busy
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [IDX_W-1:0]               second_idx,
  output logic [DATA_SIZE:0]             class_margin
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

  localparam logic [12:0] ADDR_BEST = 13'(RESULT_ADDR);
  localparam logic [12:0] ADDR_SECOND = 13'(RESULT_ADDR + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t state_reg, state_next;

  logic [DATA_SIZE-1:0] score_in_w [NUM_CLASSES];
  logic [DATA_SIZE-1:0] score_reg  [NUM_CLASSES];
  logic                 accept_w;

  logic [IDX_W-1:0]     cnt_reg, cnt_next;
  logic [DATA_SIZE-1:0] best_reg, best_next;
  logic [IDX_W-1:0]     best_idx_reg, best_idx_next;
  logic                 ena_reg, ena_next;
  logic [12:0]          addra_reg, addra_next;
  logic [DATA_SIZE-1:0] dina_reg, dina_next;
  logic [IDX_W-1:0]     class_idx_reg, class_idx_next;
  logic [DATA_SIZE-1:0] class_score_reg, class_score_next;
  logic                 class_valid_reg, class_valid_next;
  logic                 busy_reg, busy_next;
  logic [DATA_SIZE-1:0] cur_score_w;
`ifdef ARGMAX_TOP2_EN
  logic [DATA_SIZE-1:0] second_reg, second_next;
  logic [IDX_W-1:0]     second_idx_reg, second_idx_next;
  logic [IDX_W-1:0]     out_second_idx_reg, out_second_idx_next;
  logic [DATA_SIZE:0]   margin_reg, margin_next;
  logic                 wr_sel_reg, wr_sel_next;
`endif

  // Slice the packed input bus into one word per class.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign score_in_w[gi] = scores_in[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  assign cur_score_w = score_reg[cnt_reg];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and next-value logic; all outputs are registered from these values.
  always_comb begin
    state_next       = state_reg;
    accept_w         = 1'b0;
    cnt_next         = cnt_reg;
    best_next        = best_reg;
    best_idx_next    = best_idx_reg;
    ena_next         = 1'b0;
    addra_next       = '0;
    dina_next        = '0;
    class_idx_next   = class_idx_reg;
    class_score_next = class_score_reg;
    class_valid_next = 1'b0;
    busy_next        = busy_reg;
`ifdef ARGMAX_TOP2_EN
    second_next         = second_reg;
    second_idx_next     = second_idx_reg;
    out_second_idx_next = out_second_idx_reg;
    margin_next         = margin_reg;
    wr_sel_next         = wr_sel_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        // busy is still high during the class_valid cycle; drop it here and
        // refuse new vectors until it has dropped.
        busy_next = 1'b0;
        if (argmax_en && scores_valid && !busy_reg) begin
          accept_w      = 1'b1;
          best_next     = score_in_w[0];
          best_idx_next = '0;
          cnt_next      = IDX_W'(1);
          busy_next     = 1'b1;
`ifdef ARGMAX_TOP2_EN
          second_next     = {1'b1, {(DATA_SIZE-1){1'b0}}};
          second_idx_next = '1;
          wr_sel_next     = 1'b0;
`endif
          state_next    = S_SCAN;
        end
      end
      S_SCAN: begin
        if ($signed(cur_score_w) > $signed(best_reg)) begin
          best_next     = cur_score_w;
          best_idx_next = cnt_reg;
`ifdef ARGMAX_TOP2_EN
          second_next     = best_reg;
          second_idx_next = best_idx_reg;
`endif
        end
`ifdef ARGMAX_TOP2_EN
        else if ($signed(cur_score_w) > $signed(second_reg)) begin
          second_next     = cur_score_w;
          second_idx_next = cnt_reg;
        end
`endif
        cnt_next = cnt_reg + IDX_W'(1);
        if (cnt_reg == LAST_IDX) state_next = S_WRITE;
      end
      S_WRITE: begin
        ena_next   = 1'b1;
        addra_next = ADDR_BEST;
        dina_next  = {{(DATA_SIZE-IDX_W){1'b0}}, best_idx_reg};
`ifdef ARGMAX_TOP2_EN
        if (wr_sel_reg) begin
          addra_next  = ADDR_SECOND;
          dina_next   = {{(DATA_SIZE-IDX_W){1'b0}}, second_idx_reg};
          wr_sel_next = 1'b0;
          state_next  = S_DONE;
        end else begin
          wr_sel_next = 1'b1;
        end
`else
        state_next = S_DONE;
`endif
      end
      S_DONE: begin
        class_idx_next   = best_idx_reg;
        class_score_next = best_reg;
        class_valid_next = 1'b1;
`ifdef ARGMAX_TOP2_EN
        out_second_idx_next = second_idx_reg;
        margin_next = {best_reg[DATA_SIZE-1], best_reg} - {second_reg[DATA_SIZE-1], second_reg};
`endif
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output registers; the score buffer loads only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CLASSES; k++) score_reg[k] <= '0;
      cnt_reg         <= '0;
      best_reg        <= '0;
      best_idx_reg    <= '0;
      ena_reg         <= 1'b0;
      addra_reg       <= '0;
      dina_reg        <= '0;
      class_idx_reg   <= '0;
      class_score_reg <= '0;
      class_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      second_reg         <= '0;
      second_idx_reg     <= '0;
      out_second_idx_reg <= '0;
      margin_reg         <= '0;
      wr_sel_reg         <= 1'b0;
`endif
    end else begin
      if (accept_w) begin
        for (int k = 0; k < NUM_CLASSES; k++) score_reg[k] <= score_in_w[k];
      end
      cnt_reg         <= cnt_next;
      best_reg        <= best_next;
      best_idx_reg    <= best_idx_next;
      ena_reg         <= ena_next;
      addra_reg       <= addra_next;
      dina_reg        <= dina_next;
      class_idx_reg   <= class_idx_next;
      class_score_reg <= class_score_next;
      class_valid_reg <= class_valid_next;
      busy_reg        <= busy_next;
`ifdef ARGMAX_TOP2_EN
      second_reg         <= second_next;
      second_idx_reg     <= second_idx_next;
      out_second_idx_reg <= out_second_idx_next;
      margin_reg         <= margin_next;
      wr_sel_reg         <= wr_sel_next;
`endif
    end
  end

  assign result_bram_ena   = ena_reg;
  assign result_bram_wea   = ena_reg;
  assign result_bram_addra = addra_reg;
  assign result_bram_dina  = dina_reg;
  assign class_idx         = class_idx_reg;
  assign class_score       = class_score_reg;
  assign class_valid       = class_valid_reg;
  assign busy              = busy_reg;
`ifdef ARGMAX_TOP2_EN
  assign second_idx   = out_second_idx_reg;
  assign class_margin = margin_reg;
`endif

endmodule
